// File: rtl/miner_cluster_pkg.sv
// Shared types and constants for the miner cluster golden-nonce path.
package miner_cluster_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } tx_state_e;

  localparam int          TX_TIMEOUT    = 4;
  localparam logic [31:0] LAST_PUSH_RST = 32'hFFFF_FFFF;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [4:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {12'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/golden_fifo.sv
// Synchronous FIFO with registered occupancy; DEPTH must be a power of two.
module golden_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign level = cnt_q;

endmodule

// File: rtl/golden_nonce_arbiter.sv
// Per-core holding registers, round-robin drain into a FIFO, and a send/busy transmit FSM.
// Optional DUP_FILTER_EN: discard a granted nonce equal to the last one pushed.
module golden_nonce_arbiter
  import miner_cluster_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          hash_clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          core_valid,
  input  logic [NUM_CORES*32-1:0]       core_nonce,
  output logic [31:0]                   tx_word,
  output logic                          tx_send,
  input  logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [15:0]                   drop_count
);
  localparam int IW = $clog2(NUM_CORES);

  logic [NUM_CORES-1:0]        pend_q, pend_d, gnt_vec, drop_vec;
  logic [NUM_CORES-1:0][31:0]  hold_q, hold_d;
  logic [IW-1:0]               ptr_q, ptr_d, gnt_idx;
  logic                        gnt_vld, arb_en;
  logic [IW:0]                 ndrop;
  logic [15:0]                 drop_q, drop_d;
  logic                        ovf_q, ovf_d;
  logic                        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]                 push_data, fifo_head;

  tx_state_e   state_q;
  logic [31:0] tx_word_q;
  logic        tx_send_q;
  logic [2:0]  to_cnt_q;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
    int s;
    s = k;
    s = s + p;
    if (s >= NUM_CORES) s = s - NUM_CORES;
    return s[IW-1:0];
  endfunction

  assign fifo_pop = (state_q == IDLE) && !fifo_empty && !tx_busy;
  assign arb_en   = !fifo_full || fifo_pop;

  // Scan from farthest to nearest so the nearest pending core after ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (arb_en) begin
      for (int k = NUM_CORES; k >= 1; k--) begin
        if (pend_q[wrap_idx(ptr_q, k)]) begin
          gnt_vld = 1'b1;
          gnt_idx = wrap_idx(ptr_q, k);
        end
      end
    end
    ptr_d     = gnt_vld ? gnt_idx : ptr_q;
    push_data = hold_q[gnt_idx];
  end

  always_comb begin
    ndrop = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      gnt_vec[i]  = gnt_vld && (gnt_idx == IW'(i));
      pend_d[i]   = pend_q[i] && !gnt_vec[i];
      hold_d[i]   = hold_q[i];
      drop_vec[i] = 1'b0;
      if (core_valid[i]) begin
        if (pend_q[i] && !gnt_vec[i]) begin
          drop_vec[i] = 1'b1;
        end else begin
          pend_d[i] = 1'b1;
          hold_d[i] = core_nonce[32*i +: 32];
        end
      end
      ndrop = ndrop + (IW+1)'(drop_vec[i]);
    end
    drop_d = sat_add16(drop_q, 5'(ndrop));
    ovf_d  = ovf_q || (|drop_vec);
  end

`ifdef DUP_FILTER_EN
  logic [31:0] last_q, last_d;

  always_comb begin
    fifo_push = gnt_vld && (push_data != last_q);
    last_d    = fifo_push ? push_data : last_q;
  end

  always_ff @(posedge hash_clk) begin
    if (reset) last_q <= LAST_PUSH_RST;
    else       last_q <= last_d;
  end
`else
  assign fifo_push = gnt_vld;
`endif

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      pend_q <= '0;
      hold_q <= '0;
      ptr_q  <= '0;
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      hold_q <= hold_d;
      ptr_q  <= ptr_d;
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
    end
  end

  golden_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk   (hash_clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (push_data),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // The pop happens on the IDLE->SEND edge so the head lands in tx_word with the strobe.
  always_ff @(posedge hash_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_word_q <= '0;
      tx_send_q <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      tx_send_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fifo_pop) begin
            state_q   <= SEND;
            tx_send_q <= 1'b1;
            tx_word_q <= fifo_head;
          end
        end
        SEND: begin
          state_q  <= WAIT_HI;
          to_cnt_q <= '0;
        end
        WAIT_HI: begin
          if (tx_busy)                              state_q <= WAIT_LO;
          else if (to_cnt_q == 3'(TX_TIMEOUT - 1)) state_q <= IDLE;
          else                                      to_cnt_q <= to_cnt_q + 3'd1;
        end
        WAIT_LO: begin
          if (!tx_busy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_word    = tx_word_q;
  assign tx_send    = tx_send_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_golden_nonce_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a queue-based model.
module tb_golden_nonce_arbiter;
  localparam int NC = 4;
  localparam int FD = 8;
  localparam int LW = $clog2(FD) + 1;

  logic              hash_clk = 1'b0;
  logic              reset = 1'b1;
  logic [NC-1:0]     core_valid = '0;
  logic [NC*32-1:0]  core_nonce = '0;
  logic              tx_busy = 1'b0;
  logic [31:0]       tx_word;
  logic              tx_send;
  logic [LW-1:0]     fifo_level;
  logic              overflow;
  logic [15:0]       drop_count;

  golden_nonce_arbiter #(.NUM_CORES(NC), .FIFO_DEPTH(FD)) dut (
    .hash_clk   (hash_clk),
    .reset      (reset),
    .core_valid (core_valid),
    .core_nonce (core_nonce),
    .tx_word    (tx_word),
    .tx_send    (tx_send),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 hash_clk = ~hash_clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: pending flags + held words per core, FIFO as a queue.
  bit          mpend [NC];
  logic [31:0] mhold [NC];
  logic [31:0] mq [$];
  int          mptr, mst, mcnt, mdrop;
  logic [31:0] mword;
  bit          msend, movf;
`ifdef DUP_FILTER_EN
  logic [31:0] mlast;
`endif

  int          xm_mode, xm_wait, xm_len, cyc;
  logic [31:0] sent_q [$];
  int          sent_cyc [$];

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin mpend[i] = 0; mhold[i] = '0; end
    mq.delete();
    mptr = 0; mst = 0; mcnt = 0; mdrop = 0;
    mword = '0; msend = 0; movf = 0;
`ifdef DUP_FILTER_EN
    mlast = 32'hFFFF_FFFF;
`endif
  endtask

  task automatic model_step();
    int gnt;
    bit pop, push;
    logic [31:0] pv;
    if (reset) begin model_reset(); return; end
    gnt = -1;
    pv = '0;
    pop = (mst == 0) && (mq.size() > 0) && !tx_busy;
    if (mq.size() < FD || pop)
      for (int k = 1; k <= NC; k++)
        if (gnt < 0 && mpend[(mptr + k) % NC]) gnt = (mptr + k) % NC;
    push = 0;
    if (gnt >= 0) begin
      pv = mhold[gnt];
      push = 1;
`ifdef DUP_FILTER_EN
      if (pv == mlast) push = 0;
`endif
    end
    msend = 0;
    case (mst)
      0: if (pop) begin mst = 1; msend = 1; mword = mq[0]; end
      1: begin mst = 2; mcnt = 0; end
      2: if (tx_busy) mst = 3; else if (mcnt == 3) mst = 0; else mcnt++;
      default: if (!tx_busy) mst = 0;
    endcase
    if (pop) mq.delete(0);
    if (push) begin
      mq.push_back(pv);
`ifdef DUP_FILTER_EN
      mlast = pv;
`endif
    end
    for (int i = 0; i < NC; i++) begin
      if (core_valid[i]) begin
        if (mpend[i] && gnt != i) begin
          if (mdrop < 16'hFFFF) mdrop++;
          movf = 1;
        end else begin
          mpend[i] = 1;
          mhold[i] = core_nonce[32*i +: 32];
        end
      end else if (gnt == i) begin
        mpend[i] = 0;
      end
    end
    if (gnt >= 0) mptr = gnt;
  endtask

  // One clock: advance model, compare, then act as the transmitter for the next cycle.
  task automatic step();
    @(posedge hash_clk);
    model_step();
    cyc++;
    #1;
    chk("tx_send", 32'(tx_send), 32'(msend));
    chk("tx_word", tx_word, mword);
    chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
    chk("overflow", 32'(overflow), 32'(movf));
    chk("drop_count", 32'(drop_count), 32'(mdrop));
    if (tx_send) begin sent_q.push_back(tx_word); sent_cyc.push_back(cyc); end
    case (xm_mode)
      0: tx_busy = 1'b0;
      2: tx_busy = 1'b1;
      default: begin
        if (tx_send) begin
          xm_wait = $urandom_range(0, 2);
          xm_len  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 5);
        end
        if (xm_wait > 0)     begin xm_wait--; tx_busy = 1'b0; end
        else if (xm_len > 0) begin xm_len--;  tx_busy = 1'b1; end
        else                 tx_busy = 1'b0;
      end
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1; core_valid = '0; xm_mode = 0; tx_busy = 1'b0; xm_wait = 0; xm_len = 0;
    step(); step();
    reset = 1'b0;
    sent_q.delete(); sent_cyc.delete();
  endtask

  task automatic set_nonce(input int core, input logic [31:0] v);
    core_nonce[32*core +: 32] = v;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_sends;
    cyc = 0; xm_mode = 0; xm_wait = 0; xm_len = 0;
    model_reset();

    // Reset state
    reset = 1'b1;
    step(); step();
    chk("rst_tx_word", tx_word, 32'h0);
    chk("rst_tx_send", 32'(tx_send), 32'h0);
    chk("rst_level", 32'(fifo_level), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_drop", 32'(drop_count), 32'h0);
    reset = 1'b0;

    // Single report: strobe three cycles after the pulse
    set_nonce(2, 32'h1234ABCD); core_valid = 4'b0100;
    step(); core_valid = '0;
    step(); step();
    chk("t1_send_latency", 32'(tx_send), 32'h1);
    chk("t1_word", tx_word, 32'h1234ABCD);
    repeat (6) step();
    chk("t1_level_empty", 32'(fifo_level), 32'h0);

    // Fairness from pointer 0
    do_reset(); xm_mode = 1;
    for (int i = 0; i < NC; i++) set_nonce(i, 32'h10 + i);
    core_valid = 4'b1111;
    step(); core_valid = '0;
    repeat (80) step();
    chk("t2_count", 32'(sent_q.size()), 32'd4);
    if (sent_q.size() == 4) begin
      chk("t2_order0", sent_q[0], 32'h11);
      chk("t2_order1", sent_q[1], 32'h12);
      chk("t2_order2", sent_q[2], 32'h13);
      chk("t2_order3", sent_q[3], 32'h10);
    end

    // Backpressure: FIFO fills, two held entries, then two collisions
    do_reset(); xm_mode = 2; tx_busy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_nonce(k % 2, 32'h100 + k);
      core_valid = (k % 2 == 0) ? 4'b0001 : 4'b0010;
      step();
    end
    set_nonce(0, 32'h10A); set_nonce(1, 32'h10B); core_valid = 4'b0011;
    step(); core_valid = '0;
    repeat (3) step();
    chk("t3_level_full", 32'(fifo_level), 32'd8);
    chk("t3_overflow", 32'(overflow), 32'h1);
    chk("t3_drops", 32'(drop_count), 32'd2);
    xm_mode = 1;
    repeat (200) step();
    chk("t3_count", 32'(sent_q.size()), 32'd10);
    if (sent_q.size() == 10)
      for (int i = 0; i < 10; i++) chk("t3_order", sent_q[i], 32'h100 + i);

    // Grant and new valid on the same core in the same cycle
    do_reset(); xm_mode = 1;
    set_nonce(1, 32'hA1A1_0001); core_valid = 4'b0010;
    step();
    set_nonce(1, 32'hB2B2_0002);
    step(); core_valid = '0;
    repeat (40) step();
    chk("t4_count", 32'(sent_q.size()), 32'd2);
    if (sent_q.size() == 2) begin
      chk("t4_first", sent_q[0], 32'hA1A1_0001);
      chk("t4_second", sent_q[1], 32'hB2B2_0002);
    end
    chk("t4_drops", 32'(drop_count), 32'h0);

    // Handshake timeout: busy never rises
    do_reset(); xm_mode = 0;
    set_nonce(0, 32'h5A5A_0000); set_nonce(3, 32'h5A5A_0003); core_valid = 4'b1001;
    step(); core_valid = '0;
    repeat (20) step();
    chk("t5_count", 32'(sent_q.size()), 32'd2);
    if (sent_q.size() == 2) begin
      chk("t5_first", sent_q[0], 32'h5A5A_0003);
      chk("t5_second", sent_q[1], 32'h5A5A_0000);
      chk("t5_spacing", 32'(sent_cyc[1] - sent_cyc[0]), 32'd6);
    end

    // Duplicate nonce from two cores on consecutive cycles
    do_reset(); xm_mode = 1;
    set_nonce(0, 32'hDEADBEEF); core_valid = 4'b0001;
    step();
    set_nonce(3, 32'hDEADBEEF); core_valid = 4'b1000;
    step(); core_valid = '0;
    repeat (40) step();
`ifdef DUP_FILTER_EN
    exp_sends = 1;
`else
    exp_sends = 2;
`endif
    chk("t6_sends", 32'(sent_q.size()), 32'(exp_sends));
    chk("t6_drops", 32'(drop_count), 32'h0);

    // Randomized traffic with busy bursts and a reset mid-stream
    do_reset(); xm_mode = 1;
    for (int c = 0; c < 1500; c++) begin
      if (c % 300 == 150) xm_mode = 2;
      if (c % 300 == 200) xm_mode = 1;
      for (int i = 0; i < NC; i++) begin
        core_valid[i] = ($urandom_range(0, 5) == 0);
        set_nonce(i, 32'hC0DE_0000 | 32'($urandom_range(0, 7)));
      end
      reset = (c == 777);
      step();
    end
    reset = 1'b0; core_valid = '0; xm_mode = 1;
    repeat (200) step();
    chk("rand_drained", 32'(fifo_level), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
